// File: rtl/mips_sequencer_pkg.sv
// Shared MIPS control definitions: sequencer state encodings and opcode constants.
// Imported by the sequencer, the opcode classifier and the control decoder.
package mips_sequencer_pkg;

    typedef enum logic [3:0] {
        FETCH            = 4'd0,
        READ_FROM_MEMORY = 4'd1,
        DECODE           = 4'd2,
        EXECUTE          = 4'd3,
        EXECUTE_IMM      = 4'd4,
        ALU_WRITEBACK    = 4'd5,
        MEMADDR          = 4'd6,
        MEMREAD          = 4'd7,
        MEM_WRITEBACK    = 4'd8,
        MEMWRITE         = 4'd9,
        IDLE             = 4'd10,
        FAULT            = 4'd11
    } state_t;

    localparam logic [5:0] OPRTYPE = 6'b000000;
    localparam logic [5:0] ADDI    = 6'b001000;
    localparam logic [5:0] SLTI    = 6'b001010;
    localparam logic [5:0] ANDI    = 6'b001100;
    localparam logic [5:0] ORI     = 6'b001101;
    localparam logic [5:0] XORI    = 6'b001110;
    localparam logic [5:0] LW      = 6'b100011;
    localparam logic [5:0] SW      = 6'b101011;

    // Recorded as the faulting opcode when the state register holds an unused code.
    localparam logic [5:0] BAD_STATE_OPCODE = 6'h3F;

endpackage

// File: rtl/mips_sequencer_op_classify.sv
// Combinational opcode classifier: sorts the instruction-register opcode into
// the instruction classes the sequencer routes on.
module op_classify
    import mips_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_rtype,
    output logic       is_imm,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_illegal
);

    assign is_rtype   = (opcode == OPRTYPE);
    assign is_imm     = (opcode inside {ADDI, SLTI, ANDI, ORI, XORI});
    assign is_lw      = (opcode == LW);
    assign is_sw      = (opcode == SW);
    assign is_illegal = ~(is_rtype | is_imm | is_lw | is_sw);

endmodule

// File: rtl/mips_sequencer.sv
// Multicycle MIPS control sequencer: Moore state register, next-state logic,
// retired-instruction counter and fault capture.
module mips_sequencer
    import mips_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  logic        ena,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic [3:0]  state,
    output logic        instr_retired,
    output logic [31:0] retired_count,
    output logic        fault,
    output logic [5:0]  fault_opcode
);

    state_t state_q;
    state_t state_d;
    logic   is_rtype;
    logic   is_imm;
    logic   is_lw;
    logic   is_sw;
    logic   is_illegal;
    logic   enter_fault;
    logic   bad_code;

    op_classify u_op_classify (
        .opcode     (opcode),
        .is_rtype   (is_rtype),
        .is_imm     (is_imm),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_illegal (is_illegal)
    );

    assign state       = state_q;
    assign bad_code    = (state_q > FAULT);
    assign enter_fault = (state_d == FAULT) && (state_q != FAULT);

    always_comb begin
        state_d       = state_q;
        instr_retired = 1'b0;
        case (state_q)
            IDLE:             if (ena) state_d = FETCH;
            FETCH:            state_d = READ_FROM_MEMORY;
            READ_FROM_MEMORY: if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (is_illegal)    state_d = FAULT;
                else if (is_rtype) state_d = EXECUTE;
                else if (is_imm)   state_d = EXECUTE_IMM;
                else               state_d = MEMADDR;
            end
            EXECUTE,
            EXECUTE_IMM:      state_d = ALU_WRITEBACK;
            // Opcode is expected stable past DECODE; a change here is treated as illegal.
            MEMADDR: begin
                if (is_lw)      state_d = MEMREAD;
                else if (is_sw) state_d = MEMWRITE;
                else            state_d = FAULT;
            end
            MEMREAD:          if (mem_ready) state_d = MEM_WRITEBACK;
            ALU_WRITEBACK,
            MEM_WRITEBACK: begin
                instr_retired = 1'b1;
                state_d       = ena ? FETCH : IDLE;
            end
            MEMWRITE: begin
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = ena ? FETCH : IDLE;
                end
            end
            FAULT:            state_d = FAULT;
            default:          state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q       <= IDLE;
            retired_count <= 32'd0;
            fault         <= 1'b0;
            fault_opcode  <= 6'd0;
        end else begin
            state_q <= state_d;
            if (instr_retired) retired_count <= retired_count + 32'd1;
            if (enter_fault) begin
                fault        <= 1'b1;
                fault_opcode <= bad_code ? BAD_STATE_OPCODE : opcode;
            end
        end
    end

endmodule

// File: tb/tb_mips_sequencer.sv
// Self-checking bench for mips_sequencer: instruction-level trace model driving
// randomized handshakes, per-cycle comparison and directed corner cases.
module tb_mips_sequencer;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  state;
    logic        instr_retired;
    logic [31:0] retired_count;
    logic        fault;
    logic [5:0]  fault_opcode;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    int          exp_state = 10;
    bit          exp_ret = 1'b0;
    logic [31:0] exp_cnt = 32'd0;
    bit          exp_fault = 1'b0;
    logic [5:0]  exp_fop = 6'd0;
    int          lat_cnt = 0;
    int          lat;

    mips_sequencer dut (
        .clk           (clk),
        .rstb          (rstb),
        .ena           (ena),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .state         (state),
        .instr_retired (instr_retired),
        .retired_count (retired_count),
        .fault         (fault),
        .fault_opcode  (fault_opcode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(exp_state));
            check("instr_retired", 32'(instr_retired), 32'(exp_ret));
            check("retired_count", retired_count, exp_cnt);
            check("fault", 32'(fault), 32'(exp_fault));
            check("fault_opcode", 32'(fault_opcode), 32'(exp_fop));
        end
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit pick(input int mode);
        return (mode == 2) ? rb() : (mode != 0);
    endfunction

    // One clock cycle of the expected trace: the state the DUT must be in and the inputs it sees.
    task automatic cyc(input int st, input bit mr, input bit en, input bit ret);
        @(posedge clk);
        #2;
        if (exp_ret) exp_cnt = exp_cnt + 32'd1;
        exp_ret   = ret;
        exp_state = st;
        mem_ready = mr;
        ena       = en;
        if (st == 11 && !exp_fault) begin
            exp_fault = 1'b1;
            exp_fop   = opcode;
        end
        lat_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(10, rb(), 1'b0, 1'b0);
        cyc(10, rb(), 1'b1, 1'b0);
    endtask

    // Expected trace of one instruction starting at FETCH, built from its class and wait counts.
    task automatic instr(input logic [5:0] op, input int wr, input int wm, input int ena_fl,
                         input bit en_end, output int latency);
        lat_cnt = 0;
        cyc(0, rb(), pick(ena_fl), 1'b0);
        opcode = op;
        for (int i = 0; i < wr; i++) cyc(1, 1'b0, pick(ena_fl), 1'b0);
        cyc(1, 1'b1, pick(ena_fl), 1'b0);
        cyc(2, rb(), pick(ena_fl), 1'b0);
        if (op == 6'b000000) begin
            cyc(3, rb(), pick(ena_fl), 1'b0);
            cyc(5, rb(), en_end, 1'b1);
        end else if (op == 6'd8 || op == 6'd10 || op == 6'd12 || op == 6'd13 || op == 6'd14) begin
            cyc(4, rb(), pick(ena_fl), 1'b0);
            cyc(5, rb(), en_end, 1'b1);
        end else if (op == 6'd35) begin
            cyc(6, rb(), pick(ena_fl), 1'b0);
            for (int i = 0; i < wm; i++) cyc(7, 1'b0, pick(ena_fl), 1'b0);
            cyc(7, 1'b1, pick(ena_fl), 1'b0);
            cyc(8, rb(), en_end, 1'b1);
        end else if (op == 6'd43) begin
            cyc(6, rb(), pick(ena_fl), 1'b0);
            for (int i = 0; i < wm; i++) cyc(9, 1'b0, pick(ena_fl), 1'b0);
            cyc(9, 1'b1, en_end, 1'b1);
        end else begin
            cyc(11, rb(), rb(), 1'b0);
        end
        latency = lat_cnt;
    endtask

    task automatic reset_model();
        exp_state = 10;
        exp_ret   = 1'b0;
        exp_cnt   = 32'd0;
        exp_fault = 1'b0;
        exp_fop   = 6'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal_ops [8];
        bit         en_end;
        legal_ops = '{6'd0, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};

        rstb = 1'b0; ena = 1'b1; opcode = 6'h15; mem_ready = 1'b1;
        #13;
        check("reset_state", 32'(state), 32'd10);
        check("reset_count", retired_count, 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_fault_opcode", 32'(fault_opcode), 32'd0);
        check("reset_retired", 32'(instr_retired), 32'd0);
        ena = 1'b0;
        #9;
        rstb = 1'b1;
        chk_en = 1'b1;

        idle(3);
        instr(6'b000000, 0, 0, 1, 1'b1, lat);
        check("rtype_latency", 32'(lat), 32'd5);
        instr(6'b100011, 0, 3, 2, 1'b1, lat);
        check("lw_wait_latency", 32'(lat), 32'd9);
        check("count_after_rtype", retired_count, 32'd1);
        instr(6'b101011, 0, 0, 2, 1'b1, lat);
        check("sw_latency", 32'(lat), 32'd5);
        check("sw_retire_at_memwrite", 32'(instr_retired), 32'd1);
        instr(6'b001101, 0, 0, 0, 1'b0, lat);
        check("imm_latency", 32'(lat), 32'd5);
        cyc(10, rb(), 1'b0, 1'b0);
        check("count_after_four", retired_count, 32'd4);

        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        exp_cnt = 32'hFFFF_FFFF;
        idle(2);
        instr(6'b000000, 0, 0, 2, 1'b0, lat);
        cyc(10, rb(), 1'b0, 1'b0);
        check("count_wrap", retired_count, 32'd0);
        idle(0);

        instr(6'b100011, 0, 0, 1, 1'b1, lat);
        check("lw_latency", 32'(lat), 32'd6);
        for (int k = 0; k < 40; k++) begin
            en_end = rb();
            instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                  2, en_end, lat);
            if (!en_end) idle($urandom_range(0, 2));
        end

        cyc(0, rb(), 1'b1, 1'b0);
        opcode = 6'b100011;
        cyc(1, 1'b1, 1'b1, 1'b0);
        cyc(2, rb(), 1'b1, 1'b0);
        cyc(6, rb(), 1'b1, 1'b0);
        chk_en = 1'b0;
        #1;
        rstb = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd10);
        check("async_reset_count", retired_count, 32'd0);
        check("async_reset_retired", 32'(instr_retired), 32'd0);
        ena = 1'b0;
        @(posedge clk);
        #3;
        check("reset_held_state", 32'(state), 32'd10);
        rstb = 1'b1;
        reset_model();
        chk_en = 1'b1;

        idle(1);
        instr(6'b000010, 0, 0, 2, 1'b1, lat);
        for (int i = 0; i < 20; i++) cyc(11, rb(), 1'b1 ^ i[0], 1'b0);
        check("fault_state", 32'(state), 32'd11);
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_opcode_02", 32'(fault_opcode), 32'h02);
        chk_en = 1'b0;
        #1;
        rstb = 1'b0;
        #1;
        check("fault_reset_state", 32'(state), 32'd10);
        check("fault_reset_flag", 32'(fault), 32'd0);
        check("fault_reset_opcode", 32'(fault_opcode), 32'd0);
        #20;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_sequencer.md
MIPS_SEQUENCER -- requirements
Module: mips_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rstb  input  1  reset, asynchronous, active-low.
REQ-003 ena  input  1  run enable; sampled only in IDLE and at instruction completion.
REQ-004 opcode  input  6  opcode field of the instruction register; valid from DECODE onward.
REQ-005 mem_ready  input  1  memory handshake; 1 = current memory access completes this cycle.
REQ-006 state  output  4  registered current state; feeds the control decoder directly.
REQ-007 instr_retired  output  1  combinational pulse; high in the final cycle of each completed instruction.
REQ-008 retired_count  output  32  registered count of retired instructions.
REQ-009 fault  output  1  registered; high while in FAULT.
REQ-010 fault_opcode  output  6  registered; opcode that caused FAULT.

Function
REQ-011 States and encodings: FETCH 0, READ_FROM_MEMORY 1, DECODE 2, EXECUTE 3, EXECUTE_IMM 4, ALU_WRITEBACK 5, MEMADDR 6, MEMREAD 7, MEM_WRITEBACK 8, MEMWRITE 9, IDLE 10, FAULT 11; codes 12-15 unused.
REQ-012 Moore machine: state changes only on a clock edge, and every transition takes exactly one edge.
REQ-013 IDLE: go to FETCH if ena=1, else hold.
REQ-014 FETCH: always go to READ_FROM_MEMORY.
REQ-015 READ_FROM_MEMORY: go to DECODE if mem_ready=1, else hold.
REQ-016 DECODE: route by opcode as follows.
- 000000 (R-type): EXECUTE.
- 001000, 001010, 001100, 001101, 001110 (ADDI, SLTI, ANDI, ORI, XORI): EXECUTE_IMM.
- 100011 (LW) or 101011 (SW): MEMADDR.
- Any other opcode: FAULT.
REQ-017 EXECUTE and EXECUTE_IMM: go to ALU_WRITEBACK.
REQ-018 MEMADDR: go to MEMREAD for LW; go to MEMWRITE for SW.
REQ-019 MEMREAD: go to MEM_WRITEBACK if mem_ready=1, else hold.
REQ-020 MEMWRITE: hold while mem_ready=0; on mem_ready=1 the instruction completes.
REQ-021 Completion points are ALU_WRITEBACK, MEM_WRITEBACK, and MEMWRITE with mem_ready=1; next state is FETCH if ena=1, else IDLE.
REQ-022 instr_retired is 1 exactly at the completion points of REQ-021, otherwise 0.
REQ-023 retired_count increments on the same edge that ends a completion cycle; it wraps 0xFFFFFFFF -> 0x00000000 with no flag.
REQ-024 A deasserted ena never interrupts an instruction in flight; the sequencer stops only at IDLE.
REQ-025 FAULT behaviour:
- On the edge entering FAULT, fault_opcode captures opcode and fault goes to 1.
- FAULT is absorbing: it ignores ena and mem_ready and exits only by reset.
REQ-026 An unused state code (12-15) next-states to FAULT, with fault_opcode = 6'h3F.
REQ-027 Instruction latency with mem_ready held at 1:
- R-type and I-type ALU: 5 cycles, FETCH through ALU_WRITEBACK.
- LW: 6 cycles.
- SW: 5 cycles.
- Each mem_ready=0 cycle in a waiting state adds one cycle.

Reset
REQ-028 While rstb=0, the outputs are forced immediately (asynchronously) and held:
- state = IDLE.
- retired_count = 0.
- fault = 0.
- fault_opcode = 0.
- instr_retired = 0.
REQ-029 Reset asserted mid-instruction or in FAULT abandons all progress; there is no partial retire and no count update.
REQ-030 After rstb rises, the first state change happens at the first rising edge at which ena=1 is sampled.

Structure
REQ-031 The state encodings and the opcode constants (OPRTYPE, LW, SW, and the immediate ALU ops) live in the shared MIPS defines header used by the control decoder, and are not duplicated locally.
REQ-032 Opcode classification is a combinational sub-module, op_classify, with:
- input: opcode.
- outputs: is_rtype, is_imm, is_lw, is_sw, is_illegal.
REQ-033 The sequencer contains only the state register, next-state logic, retire counter and fault capture registers.

Verification
REQ-034 Reset, then ena=1 with opcode=000000 and mem_ready=1:
- states visited: IDLE, FETCH, READ_FROM_MEMORY, DECODE, EXECUTE, ALU_WRITEBACK, FETCH.
- instr_retired pulses once and retired_count=1.
REQ-035 opcode=100011 (LW) with mem_ready=0 for 3 cycles in MEMREAD:
- MEMREAD persists for 4 cycles, then MEM_WRITEBACK follows.
- total latency is 9 cycles and retired_count increments by 1.
REQ-036 SW (101011) with mem_ready=1: sequence reaches MEMWRITE, instr_retired=1 there, and the next state is FETCH; MEM_WRITEBACK never appears.
REQ-037 opcode=000010 at DECODE:
- next state is FAULT, fault=1, fault_opcode=6'h02.
- 20 further cycles with ena toggling leave state at 11.
- rstb low clears to IDLE.
REQ-038 ena dropped during EXECUTE_IMM: the instruction completes through ALU_WRITEBACK and the next state is IDLE, held until ena=1.
REQ-039 Two corner cases:
- Preload the count to 0xFFFFFFFF (force): one retire yields 0x00000000.
- Assert rstb low in the middle of MEMADDR: state becomes IDLE without waiting for a clock edge.
